// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 frame scheduler slice.
// Holds the scheduler state encoding, frame field widths and a width helper.
package tm1638_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_START = 3'd2,
    ST_ACK   = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  localparam int LED_W   = 8;
  localparam int NIB_W   = 4;
  localparam int NIB_CNT = 8;
  localparam int SEG_W   = NIB_W * NIB_CNT;
  localparam int OWNER_W = 3;

  // Counter/index width that never collapses to zero bits for tiny parameters.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tm1638_frame_sched_if.sv
// Bundle of frame-source request lines and the TM1638 driver handshake.
// The scheduler uses the master view; the sources/driver side uses the slave view.
interface tm1638_frame_sched_if
  import tm1638_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]       req;
  logic [LED_W*NREQ-1:0] req_led;
  logic [SEG_W*NREQ-1:0] req_seg;
  logic [NREQ-1:0]       gnt;
  logic [LED_W-1:0]      drv_led;
  logic [SEG_W-1:0]      drv_seg;
  logic                  drv_start;
  logic                  drv_busy;

  modport master (
    input  req, req_led, req_seg, drv_busy,
    output gnt, drv_led, drv_seg, drv_start
  );

  modport slave (
    output req, req_led, req_seg, drv_busy,
    input  gnt, drv_led, drv_seg, drv_start
  );

endinterface

// File: rtl/tm1638_rr_arb.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module tm1638_rr_arb
  import tm1638_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/tm1638_frame_sched.sv
// Shares one TM1638 driver between NREQ frame sources: round-robin grant, frame latch,
// start/busy handshake with acknowledge timeout, and periodic re-send of the last frame.
module tm1638_frame_sched
  import tm1638_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int REFRESH_CYC = 2_500_000,
  parameter int ACK_TMO     = 1024
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  tm1638_frame_sched_if.master bus,
  output logic [OWNER_W-1:0]   owner,
  output logic                 tmo_err
);

  localparam int IDX_W = idx_w(NREQ);
  localparam int ACK_W = idx_w(ACK_TMO);
  localparam int REF_W = idx_w(REFRESH_CYC);

  state_t           state, next_state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             win_valid;
  logic [ACK_W-1:0] ack_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             ack_last;
  logic             ref_hit;
  logic [LED_W-1:0] sel_led;
  logic [SEG_W-1:0] sel_seg;
  logic [LED_W-1:0] led_q;
  logic [SEG_W-1:0] seg_q;

  tm1638_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .winner(winner),
    .valid (win_valid)
  );

  assign ack_last    = (ack_cnt == ACK_W'(ACK_TMO - 1));
  assign ref_hit     = (ref_cnt == REF_W'(REFRESH_CYC - 1));
  assign bus.drv_led = led_q;
  assign bus.drv_seg = seg_q;

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A still-busy driver holds the scheduler in IDLE; a pending request beats the refresh.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!bus.drv_busy) begin
          if (|bus.req) begin
            next_state = ST_LATCH;
          end else if (ref_hit) begin
            next_state = ST_START;
          end
        end
      end
      ST_LATCH: next_state = win_valid ? ST_START : ST_IDLE;
      ST_START: next_state = ST_ACK;
      ST_ACK: begin
        if (bus.drv_busy) begin
          next_state = ST_RUN;
        end else if (ack_last) begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!bus.drv_busy) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = '0;
    bus.drv_start = (state == ST_START);
    for (int i = 0; i < NREQ; i++) begin
      if (state == ST_LATCH && win_valid && winner == IDX_W'(i)) begin
        bus.gnt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_led = '0;
    sel_seg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_led = bus.req_led[i*LED_W +: LED_W];
        sel_seg = bus.req_seg[i*SEG_W +: SEG_W];
      end
    end
  end

  // Frame latch, rotation pointer, handshake timeout and idle refresh timer.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      seg_q   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      ack_cnt <= '0;
      ref_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == ST_LATCH && win_valid) begin
        led_q  <= sel_led;
        seg_q  <= sel_seg;
        owner  <= OWNER_W'(winner);
        rr_ptr <= IDX_W'((int'(winner) + 1) % NREQ);
      end

      if (state == ST_ACK) begin
        ack_cnt <= ack_cnt + 1'b1;
      end else begin
        ack_cnt <= '0;
      end

      if (state == ST_ACK && !bus.drv_busy && ack_last) begin
        tmo_err <= 1'b1;
      end

      if (state == ST_IDLE && next_state == ST_IDLE) begin
        if (!ref_hit) begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end else begin
        ref_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Directed self-checking bench for tm1638_frame_sched (NREQ=2, short refresh and timeout).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tm1638_frame_sched;

  localparam int NREQ        = 2;
  localparam int REFRESH_CYC = 16;
  localparam int ACK_TMO     = 8;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic [2:0] owner;
  logic       tmo_err;

  int checks = 0;
  int errors = 0;

  tm1638_frame_sched_if #(.NREQ(NREQ)) bus ();

  tm1638_frame_sched #(
    .NREQ       (NREQ),
    .REFRESH_CYC(REFRESH_CYC),
    .ACK_TMO    (ACK_TMO)
  ) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .bus    (bus),
    .owner  (owner),
    .tmo_err(tmo_err)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(negedge clk_50M);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.req      = '0;
    bus.drv_busy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drive_busy(input int n);
    bus.drv_busy = 1'b1;
    repeat (n) tick();
    bus.drv_busy = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.drv_start, owner, tmo_err} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got gnt=%b start=%b owner=%0d tmo=%b required all 0",
               bus.gnt, bus.drv_start, owner, tmo_err);
    end
    checks++;
    if ({bus.drv_led, bus.drv_seg} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_frame: got led=%h seg=%h required 0", bus.drv_led, bus.drv_seg);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.gnt, bus.drv_start} !== 3'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got gnt=%b start=%b required 0", bus.gnt, bus.drv_start);
    end
  endtask

  task automatic test_single();
    do_reset();
    tick();
    bus.req_led = {8'h00, 8'hA5};
    bus.req_seg = {32'h0, 32'h0123_4567};
    bus.req     = 2'b01;
    tick();
    checks++;
    if (bus.gnt !== 2'b01 || bus.drv_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_gnt: got gnt=%b start=%b required gnt=01 start=0",
               bus.gnt, bus.drv_start);
    end
    tick();
    checks++;
    if (bus.drv_start !== 1'b1 || bus.gnt !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_start: got start=%b gnt=%b required start=1 gnt=00",
               bus.drv_start, bus.gnt);
    end
    checks++;
    if (bus.drv_led !== 8'hA5 || bus.drv_seg !== 32'h0123_4567 || owner !== 3'd0) begin
      errors++;
      $display("[TB] FAIL single_frame: got led=%h seg=%h owner=%0d required a5 01234567 0",
               bus.drv_led, bus.drv_seg, owner);
    end
    bus.req = '0;
    drive_busy(3);
    checks++;
    if (bus.drv_start !== 1'b0 || bus.drv_led !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_run: got start=%b led=%h required start=0 led=a5",
               bus.drv_start, bus.drv_led);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int         exp_src;
    int         n;
    logic [1:0] exp_gnt;
    logic [7:0] exp_led;
    logic [31:0] exp_seg;
    do_reset();
    tick();
    bus.req_led = {8'h22, 8'h11};
    bus.req_seg = {32'h2222_2222, 32'h1111_1111};
    bus.req     = 2'b11;
    exp_src     = 0;
    for (int f = 0; f < 4; f++) begin
      exp_gnt = (exp_src == 0) ? 2'b01 : 2'b10;
      exp_led = (exp_src == 0) ? 8'h11 : 8'h22;
      exp_seg = (exp_src == 0) ? 32'h1111_1111 : 32'h2222_2222;
      n = 0;
      while (bus.gnt === 2'b00 && n < 8) begin
        tick();
        n++;
      end
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("[TB] FAIL rr_gnt%0d: got %b required %b", f, bus.gnt, exp_gnt);
      end
      tick();
      checks++;
      if (bus.drv_start !== 1'b1 || owner !== 3'(exp_src) || bus.drv_led !== exp_led) begin
        errors++;
        $display("[TB] FAIL rr_start%0d: got start=%b owner=%0d led=%h required 1 %0d %h",
                 f, bus.drv_start, owner, bus.drv_led, exp_src, exp_led);
      end
      bus.drv_busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (bus.drv_led !== exp_led || bus.drv_seg !== exp_seg || owner !== 3'(exp_src)) begin
          errors++;
          $display("[TB] FAIL rr_stable%0d: got led=%h seg=%h owner=%0d required %h %h %0d",
                   f, bus.drv_led, bus.drv_seg, owner, exp_led, exp_seg, exp_src);
        end
      end
      bus.drv_busy = 1'b0;
      exp_src      = 1 - exp_src;
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_refresh();
    int   n;
    logic gnt_seen;
    do_reset();
    tick();
    bus.req_led = {8'h3C, 8'h00};
    bus.req_seg = {32'h89AB_CDEF, 32'h0};
    bus.req     = 2'b10;
    tick();
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("[TB] FAIL refresh_setup: got gnt=%b required 10", bus.gnt);
    end
    tick();
    bus.req = '0;
    drive_busy(2);
    for (int p = 0; p < 2; p++) begin
      n        = 0;
      gnt_seen = 1'b0;
      do begin
        tick();
        n++;
        if (bus.gnt !== 2'b00) gnt_seen = 1'b1;
      end while (bus.drv_start !== 1'b1 && n < 40);
      checks++;
      if (n != 17 || gnt_seen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL refresh_period%0d: got %0d cycles gnt_seen=%b required 17 cycles 0",
                 p, n, gnt_seen);
      end
      checks++;
      if (bus.drv_led !== 8'h3C || bus.drv_seg !== 32'h89AB_CDEF || owner !== 3'd1) begin
        errors++;
        $display("[TB] FAIL refresh_frame%0d: got led=%h seg=%h owner=%0d required 3c 89abcdef 1",
                 p, bus.drv_led, bus.drv_seg, owner);
      end
      drive_busy(2);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    bus.req_led = {8'h88, 8'h77};
    bus.req     = 2'b01;
    tick();
    tick();
    bus.req = '0;
    checks++;
    if (bus.drv_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_start: got start=%b required 1", bus.drv_start);
    end
    repeat (8) tick();
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_early: got tmo_err=%b at start+8 required 0", tmo_err);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_set: got tmo_err=%b at start+9 required 1", tmo_err);
    end
    bus.req = 2'b10;
    tick();
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("[TB] FAIL tmo_next_gnt: got gnt=%b required 10", bus.gnt);
    end
    tick();
    bus.req = '0;
    checks++;
    if (bus.drv_start !== 1'b1 || tmo_err !== 1'b1 || bus.drv_led !== 8'h88) begin
      errors++;
      $display("[TB] FAIL tmo_next_start: got start=%b tmo=%b led=%h required 1 1 88",
               bus.drv_start, tmo_err, bus.drv_led);
    end
    drive_busy(2);
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.req_led = {8'hE7, 8'h00};
    bus.req_seg = {32'hCAFE_F00D, 32'h0};
    bus.req     = 2'b10;
    tick();
    tick();
    bus.req      = '0;
    bus.drv_busy = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.drv_led !== 8'hE7 || owner !== 3'd1 || tmo_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got led=%h owner=%0d tmo=%b required e7 1 1",
               bus.drv_led, owner, tmo_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.drv_start, owner, tmo_err} !== 7'b0 ||
        {bus.drv_led, bus.drv_seg} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_clear: got gnt=%b start=%b owner=%0d tmo=%b led=%h seg=%h required 0",
               bus.gnt, bus.drv_start, owner, tmo_err, bus.drv_led, bus.drv_seg);
    end
    bus.drv_busy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      tick();
      if (bus.drv_start !== 1'b0 || bus.gnt !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_quiet: got activity=%b after release required 0", seen);
    end
  endtask

  task automatic test_req_pulse();
    logic seen;
    do_reset();
    tick();
    bus.req_led = {8'h44, 8'h33};
    bus.req     = 2'b01;
    tick();
    tick();
    bus.req      = '0;
    bus.drv_busy = 1'b1;
    tick();
    tick();
    bus.req = 2'b10;
    tick();
    bus.req      = '0;
    bus.drv_busy = 1'b0;
    seen         = 1'b0;
    repeat (6) begin
      tick();
      if (bus.gnt !== 2'b00 || bus.drv_start !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pulse_not_granted: got activity=%b required 0", seen);
    end
    repeat (10) tick();
    checks++;
    if (bus.drv_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL deadline_early: got start=%b required 0", bus.drv_start);
    end
    bus.req = 2'b10;
    tick();
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("[TB] FAIL deadline_req_wins: got gnt=%b required 10", bus.gnt);
    end
    tick();
    bus.req = '0;
    checks++;
    if (bus.drv_start !== 1'b1 || owner !== 3'd1 || bus.drv_led !== 8'h44) begin
      errors++;
      $display("[TB] FAIL deadline_frame: got start=%b owner=%0d led=%h required 1 1 44",
               bus.drv_start, owner, bus.drv_led);
    end
    drive_busy(2);
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_led  = '0;
    bus.req_seg  = '0;
    bus.drv_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_refresh();
    test_timeout();
    test_reset_mid();
    test_req_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by 500 us required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
